// File: rtl/rb_pkg.sv
// rb_pkg: shared constants and FSM state encoding for the row-buffer stream scheduler.
package rb_pkg;
   localparam int NBANK = 4;
   localparam int IMG_W_DEF = 512;
   localparam int IMG_H_DEF = 512;
   typedef logic [2:0] state_t;
   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_FILL   = 3'd1;
   localparam state_t S_STREAM = 3'd2;
   localparam state_t S_DRAIN  = 3'd3;
   localparam state_t S_DONE   = 3'd4;
endpackage

// File: rtl/rb_stream_sched_if.sv
// rb_stream_sched_if: pixel-in and window-out handshakes of the row-buffer scheduler.
interface rb_stream_sched_if #(
   parameter int IMG_W = 512,
   parameter int IMG_H = 512
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   logic          in_valid;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [RW-1:0] out_row;
   logic [CW-1:0] out_col;
   logic          out_left_edge;
   modport slave (
      input  in_valid, out_ready,
      output in_ready, out_valid, out_row, out_col, out_left_edge
   );
   modport master (
      output in_valid, out_ready,
      input  in_ready, out_valid, out_row, out_col, out_left_edge
   );
endinterface

// File: rtl/rb_pos_counter.sv
// rb_pos_counter: column/row/bank position counters advancing once per accepted pixel.
module rb_pos_counter #(
   parameter int IMG_W = 512,
   parameter int IMG_H = 512,
   localparam int CW = $clog2(IMG_W),
   localparam int RW = $clog2(IMG_H)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          inc_i,
   output logic [CW-1:0] col_o,
   output logic [RW-1:0] row_o,
   output logic [1:0]    bank_o,
   output logic          col_last_o,
   output logic          row_last_o
);
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [1:0]    bank_q, bank_d;
   assign col_last_o = col_q == CW'(IMG_W - 1);
   assign row_last_o = row_q == RW'(IMG_H - 1);
   assign col_o      = col_q;
   assign row_o      = row_q;
   assign bank_o     = bank_q;
   always_comb begin
      col_d  = clr_i ? '0 : !inc_i ? col_q : col_last_o ? '0 : col_q + 1'b1;
      row_d  = clr_i ? '0 : !(inc_i && col_last_o) ? row_q : row_last_o ? '0 : row_q + 1'b1;
      bank_d = clr_i ? '0 : (inc_i && col_last_o) ? bank_q + 2'd1 : bank_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q  <= '0;
         row_q  <= '0;
         bank_q <= '0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         bank_q <= bank_d;
      end
   end
endmodule

// File: rtl/rb_stream_sched.sv
// rb_stream_sched: schedules 4-bank row-buffer writes/reads and emits one 3x3 window
// position per pixel once two full rows are buffered.
module rb_stream_sched import rb_pkg::*; #(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF,
   localparam int CW = $clog2(IMG_W),
   localparam int RW = $clog2(IMG_H)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   rb_stream_sched_if.slave  s,
   output logic [NBANK-1:0]  wr_bank_en,
   output logic [CW-1:0]     wr_col,
   output logic              rd_en,
   output logic [CW-1:0]     rd_col,
   output logic [1:0]        top_bank,
   output logic              complete
);
   state_t        state_q, state_d;
   logic          out_valid_q, out_valid_d;
   logic [RW-1:0] out_row_q, out_row_d;
   logic [CW-1:0] out_col_q, out_col_d;
   logic          left_q, left_d;
   logic [1:0]    top_q, top_d;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [1:0]    bank;
   logic          col_last, row_last, in_rdy, accept, load, xfer;
   rb_pos_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_pos (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (start),
      .inc_i      (accept),
      .col_o      (col),
      .row_o      (row),
      .bank_o     (bank),
      .col_last_o (col_last),
      .row_last_o (row_last)
   );
   assign in_rdy = state_q == S_FILL || (state_q == S_STREAM && (!out_valid_q || s.out_ready));
   assign accept = s.in_valid && in_rdy;
   assign load   = accept && state_q == S_STREAM;
   assign xfer   = out_valid_q && s.out_ready;
   always_comb begin
      state_d = start ? S_FILL
              : (state_q == S_FILL && accept && col_last && row == RW'(1)) ? S_STREAM
              : (state_q == S_STREAM && accept && col_last && row_last) ? S_DRAIN
              : (state_q == S_DRAIN && xfer) ? S_DONE
              : state_q;
      // a new beat overwrites a window in the same cycle it is consumed
      out_valid_d = start ? 1'b0 : load ? 1'b1 : xfer ? 1'b0 : out_valid_q;
      out_row_d   = start ? '0 : load ? row : out_row_q;
      out_col_d   = start ? '0 : load ? col : out_col_q;
      left_d      = start ? 1'b0 : load ? col < CW'(2) : left_q;
      top_d       = start ? 2'd0 : load ? bank - 2'd2 : top_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         left_q      <= 1'b0;
         top_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_row_q   <= out_row_d;
         out_col_q   <= out_col_d;
         left_q      <= left_d;
         top_q       <= top_d;
      end
   end
   assign s.in_ready      = in_rdy;
   assign s.out_valid     = out_valid_q;
   assign s.out_row       = out_row_q;
   assign s.out_col       = out_col_q;
   assign s.out_left_edge = left_q;
   assign wr_bank_en      = accept ? NBANK'(1) << bank : '0;
   assign wr_col          = col;
   assign rd_en           = accept;
   assign rd_col          = col;
   assign top_bank        = top_q;
   assign complete        = state_q == S_DONE;
endmodule

// File: doc/rb_stream_sched.md
RB_STREAM_SCHED -- requirements
Module: rb_stream_sched

Interface
REQ-001 Parameter IMG_W, 512, pixels per image row; power of two, minimum 4.
REQ-002 Parameter IMG_H, 512, rows per frame; minimum 3.
REQ-003 Parameter NBANK, 4, row-buffer banks; fixed at 4, each bank IMG_W deep.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a frame.
REQ-007 in_valid / in_ready  input / output  1 / 1  pixel-stream handshake; a beat transfers when both are 1.
REQ-008 wr_bank_en  output  4  one-hot write enable, row-buffer bank.
REQ-009 wr_col  output  log2(IMG_W)  write column address.
REQ-010 rd_en / rd_col  output  1 / log2(IMG_W)  read enable to all banks, and the read column (equals wr_col).
REQ-011 top_bank  output  2  bank holding the oldest window row; used by the window-assembly mux.
REQ-012 out_valid / out_ready  output / input  1 / 1  window handshake.
REQ-013 out_row / out_col  output  log2(IMG_H) / log2(IMG_W)  coordinates of the newest pixel in the window.
REQ-014 out_left_edge  output  1  high when out_col < 2, i.e. the 3x3 window is only partially populated.
REQ-015 complete  output  1  high while in DONE.

Function
REQ-016 The FSM states SHALL be IDLE, FILL, STREAM, DRAIN and DONE.
REQ-017 FSM transitions:
- IDLE->FILL on start.
- FILL->STREAM after the last column of row 1 is accepted.
- STREAM->DRAIN after the last pixel of row IMG_H-1 is accepted.
- DRAIN->DONE when the final window transfers.
- DONE->FILL on start.
REQ-018 start SHALL clear the counters and force FILL from any state; an in-flight window is discarded.
REQ-019 in_ready SHALL be 1 in FILL always, and in STREAM when (!out_valid || out_ready); it SHALL be 0 in IDLE, DRAIN and DONE.
REQ-020 On each accepted beat the block SHALL assert wr_bank_en[wr_bank], wr_col=col and rd_en=1 in that same cycle (combinational from the handshake).
REQ-021 col SHALL increment per accepted beat and wrap at IMG_W-1 to 0; at the wrap, row SHALL increment and wr_bank SHALL advance mod 4.
REQ-022 top_bank SHALL equal (wr_bank - 2) mod 4 and SHALL be registered alongside the window outputs.
REQ-023 Beats accepted in STREAM SHALL produce out_valid one cycle later (BRAM read latency), with out_row, out_col and out_left_edge for that beat.
REQ-024 out_valid and its data SHALL hold stable until out_ready; there SHALL be no drop and no duplication.
REQ-025 A simultaneous output transfer and input accept SHALL reload the output register in the same cycle (full throughput).
REQ-026 Beats accepted in FILL SHALL produce no output.
REQ-027 Per frame the block SHALL accept exactly IMG_W*IMG_H beats (262144 at default) and emit (IMG_H-2)*IMG_W windows (261120 at default).
REQ-028 In DONE, complete=1 and all enables SHALL be 0 until start.

Reset
REQ-029 While rst=1, the following SHALL be 0 on the next edge: the state (IDLE), row, col, wr_bank, top_bank and all outputs.
REQ-030 rst SHALL take priority over start; reset mid-frame SHALL abandon the frame with no further writes.

Structure
REQ-031 Package rb_pkg SHALL hold the state enum, the NBANK constant and the IMG_W/IMG_H defaults.
REQ-032 One sub-module, rb_pos_counter (col/row/bank counters with wrap flags), SHALL be instantiated; all other logic SHALL stay flat.

Verification
REQ-033 Use IMG_W=8, IMG_H=6 with continuous valid/ready:
- the first out_valid comes one cycle after beat 16;
- 32 windows are emitted;
- complete rises after the final transfer.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles mid-STREAM -> in_ready=0 and out data stable; on release there is no lost or duplicated window.
REQ-035 Bank rotation: across 6 rows, wr_bank runs 0,1,2,3,0,1 and top_bank=(wr_bank-2) mod 4 on every window.
REQ-036 Edge flag: out_left_edge=1 exactly for out_col 0 and 1 in every output row.
REQ-037 Assert rst mid-row 3 -> all outputs 0 next cycle; a subsequent start yields a full, correct frame.
REQ-038 Pulse start in DONE and in mid-STREAM -> the counters restart at 0 and the state is FILL.
